// File: rtl/bcd_disp_pkg.sv
// ---------------------------------------------------------------------------
// bcd_disp_pkg : shared constants and types for the BCD display scanner
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bcd_disp_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [2:0] AN_OFF  = 3'b111;

  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUND = 2'd2;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  typedef struct packed {
    logic       cout;
    logic [7:0] f;
  } bcd_val_t;

  // Active-low one-hot digit enable for the selected slot.
  function automatic logic [2:0] an_sel(input logic [1:0] idx);
    case (idx)
      DIG_TENS: an_sel = 3'b101;
      DIG_HUND: an_sel = 3'b011;
      default:  an_sel = 3'b110;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_display_scan_if.sv
// ---------------------------------------------------------------------------
// bcd_display_scan_if : value capture inputs and display drive outputs
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface bcd_display_scan_if;
  logic       load;
  logic       cout;
  logic [7:0] f;
  logic [6:0] seg;
  logic [2:0] an;
  logic       pending;

  modport master (output load, output cout, output f,
                  input  seg,  input  an,   input  pending);
  modport slave  (input  load, input  cout, input  f,
                  output seg,  output an,   output pending);
endinterface

`default_nettype wire

// File: rtl/bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7 : 4-bit BCD to 7-segment decoder, "E" for values above 9
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_E;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bcd_display_scan.sv
// ---------------------------------------------------------------------------
// bcd_display_scan : tear-free 3-digit multiplexed 7-segment scanner
// Optional macro   : LEADING_ZERO_BLANK_EN (blank leading zero digits)
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  bcd_display_scan_if.slave  bus
);

  localparam int MAXC  = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bcd_val_t         shadow_q, shadow_d;
  bcd_val_t         disp_q, disp_d;
  logic             pending_q, pending_d;
  logic [2:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       digit_d;
  logic [6:0]       enc_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + CNT_W'(1);
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          // Frame start: the only point a captured value may go live.
          if (idx_q == DIG_ONES && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
          end
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == DIG_HUND) ? DIG_ONES : idx_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase

    // A load overrides the commit's pending clear, so it waits a full frame.
    if (bus.load) begin
      shadow_d  = '{cout: bus.cout, f: bus.f};
      pending_d = 1'b1;
    end
  end

  always_comb begin
    case (idx_d)
      DIG_TENS: digit_d = disp_d.f[7:4];
      DIG_HUND: digit_d = {3'b000, disp_d.cout};
      default:  digit_d = disp_d.f[3:0];
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd_i (digit_d),
    .seg_o (enc_d)
  );

  // Outputs are decoded from next state so they register on the same edge.
  always_comb begin
    seg_d = SEG_OFF;
    an_d  = AN_OFF;
    if (state_d == ST_SHOW) begin
      seg_d = enc_d;
      an_d  = an_sel(idx_d);
`ifdef LEADING_ZERO_BLANK_EN
      if ((idx_d == DIG_HUND && !disp_d.cout) ||
          (idx_d == DIG_TENS && !disp_d.cout && disp_d.f[7:4] == 4'd0)) begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_BLANK;
      idx_q     <= DIG_ONES;
      cnt_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.seg     = seg_q;
  assign bus.an      = an_q;
  assign bus.pending = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_scan.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_scan : directed vector bench, DIV=4 / BLANK_CYC=2 (18-cycle frame)
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bcd_display_scan;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h00;
`else
  localparam logic [6:0] LZ = 7'h3F;
`endif

  typedef struct packed {
    logic       cout;
    logic [7:0] f;
    logic [6:0] s1;
    logic [6:0] s10;
    logic [6:0] s100;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[8];

  bcd_display_scan_if bus ();

  bcd_display_scan #(.DIV(4), .BLANK_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_val(input logic c, input logic [7:0] v);
    bus.load = 1'b1;
    bus.cout = c;
    bus.f    = v;
    step(1);
    bus.load = 1'b0;
  endtask

  function automatic logic [2:0] exp_an(input logic [6:0] s, input logic [2:0] on);
    return (s == 7'h00) ? 3'b111 : on;
  endfunction

  // Entered and left at frame position 0 (first SHOW cycle of the ones slot).
  task automatic check_frame(input string tag, input logic [6:0] e1,
                             input logic [6:0] e10, input logic [6:0] e100);
    chk({tag, " ones seg"}, 16'(bus.seg), 16'(e1));
    chk({tag, " ones an"},  16'(bus.an),  16'(3'b110));
    step(3);
    chk({tag, " ones seg last"}, 16'(bus.seg), 16'(e1));
    step(1);
    chk({tag, " blank an"},  16'(bus.an),  16'(3'b111));
    chk({tag, " blank seg"}, 16'(bus.seg), 16'(7'h00));
    step(2);
    chk({tag, " tens seg"}, 16'(bus.seg), 16'(e10));
    chk({tag, " tens an"},  16'(bus.an),  16'(exp_an(e10, 3'b101)));
    step(6);
    chk({tag, " hund seg"}, 16'(bus.seg), 16'(e100));
    chk({tag, " hund an"},  16'(bus.an),  16'(exp_an(e100, 3'b011)));
    step(6);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h47, 7'h07, 7'h66, 7'h06};
    vecs[1] = '{1'b0, 8'hA3, 7'h4F, 7'h79, LZ};
    vecs[2] = '{1'b0, 8'h05, 7'h6D, LZ,    LZ};
    vecs[3] = '{1'b1, 8'h99, 7'h6F, 7'h6F, 7'h06};
    vecs[4] = '{1'b1, 8'h08, 7'h7F, 7'h3F, 7'h06};
    vecs[5] = '{1'b0, 8'hFC, 7'h79, 7'h79, LZ};
    vecs[6] = '{1'b0, 8'h00, 7'h3F, LZ,    LZ};
    vecs[7] = '{1'b0, 8'h26, 7'h7D, 7'h5B, LZ};

    bus.load = 1'b0;
    bus.cout = 1'b0;
    bus.f    = 8'h00;

    repeat (3) @(negedge clk);
    chk("reset an",      16'(bus.an),      16'(3'b111));
    chk("reset seg",     16'(bus.seg),     16'(7'h00));
    chk("reset pending", 16'(bus.pending), 16'(1'b0));
    rst = 1'b0;
    step(1);
    chk("post-reset blank an", 16'(bus.an), 16'(3'b111));
    step(1);
    check_frame("reset frame", 7'h3F, LZ, LZ);

    for (int i = 0; i < 8; i++) begin
      step(5);
      load_val(vecs[i].cout, vecs[i].f);
      chk($sformatf("vec%0d pending after load", i), 16'(bus.pending), 16'(1'b1));
      step(11);
      chk($sformatf("vec%0d pending before commit", i), 16'(bus.pending), 16'(1'b1));
      step(1);
      chk($sformatf("vec%0d pending after commit", i), 16'(bus.pending), 16'(1'b0));
      check_frame($sformatf("vec%0d", i), vecs[i].s1, vecs[i].s10, vecs[i].s100);
    end

    // Two loads in one frame: only the later one is shown.
    step(2);
    load_val(1'b0, 8'h12);
    step(5);
    load_val(1'b0, 8'h98);
    chk("double load pending", 16'(bus.pending), 16'(1'b1));
    step(9);
    check_frame("double load", 7'h7F, 7'h6F, LZ);
    chk("double load pending cleared", 16'(bus.pending), 16'(1'b0));

    // Load landing on the commit edge waits one more frame.
    step(4);
    load_val(1'b0, 8'h21);
    step(12);
    load_val(1'b1, 8'h56);
    chk("commit-edge load pending", 16'(bus.pending), 16'(1'b1));
    check_frame("old shadow frame", 7'h06, 7'h5B, LZ);
    chk("commit-edge load committed", 16'(bus.pending), 16'(1'b0));
    check_frame("new shadow frame", 7'h7D, 7'h6D, 7'h06);

    // Asynchronous reset in the middle of a SHOW slot.
    load_val(1'b1, 8'h99);
    chk("pre-reset pending", 16'(bus.pending), 16'(1'b1));
    chk("pre-reset an",      16'(bus.an),      16'(3'b110));
    #2 rst = 1'b1;
    #1;
    chk("async reset an",      16'(bus.an),      16'(3'b111));
    chk("async reset seg",     16'(bus.seg),     16'(7'h00));
    chk("async reset pending", 16'(bus.pending), 16'(1'b0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(1);
    chk("resume blank seg", 16'(bus.seg), 16'(7'h00));
    step(1);
    check_frame("resume frame", 7'h3F, LZ, LZ);
    chk("resume pending", 16'(bus.pending), 16'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Downstream consumer of the 2-digit BCD adder result: it takes the 8-bit packed BCD sum plus the decimal carry-out.
- Drives a 3-digit multiplexed seven-segment display:
  - hundreds digit = the carry;
  - tens digit = f[7:4];
  - ones digit = f[3:0].
- A load strobe captures the value into a shadow register. The new value goes live only at a frame boundary, so the display never tears.
- Non-BCD nibbles (greater than 9) are shown as "E".

Parameters:
- DIV, default 50000: cycles each digit is lit (SHOW time). Must be at least 1.
- BLANK_CYC, default 4: all-off cycles between digits (anti-ghosting). Must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle capture strobe for cout and f.
- cout  in  1  decimal carry from the adder.
- f  in  8  packed BCD sum: [7:4] tens, [3:0] ones.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- an  out  3  digit enables, active-low: [0] ones, [1] tens, [2] hundreds.
- pending  out  1  high while a captured value waits for the next frame start.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - state = BLANK, idx = 0, cnt = 0;
  - shadow = 0, disp = 0, pending = 0;
  - an = 3'b111, seg = 7'h00.
  - Reset asserted mid-operation forces these values immediately, without waiting for a clock edge.
- State machine (idx in {0,1,2}):
  - BLANK: an = 111, seg = 00. After BLANK_CYC cycles, go to SHOW and clear cnt.
  - SHOW: an[idx] = 0, all other an bits = 1, seg = enc(digit idx of disp). After DIV cycles, go to BLANK, clear cnt, and set idx = (idx == 2) ? 0 : idx+1.
- Outputs are Moore outputs, a pure decode of the registered state. No added latency: they change on the same edge as the state.
- Digit sources:
  - digit 0 = disp.f[3:0];
  - digit 1 = disp.f[7:4];
  - digit 2 = {3'b000, disp.cout}.
- Encoding (seg = enc(n)):

  | n | seg |
  |---|-----|
  | 0 | 3F |
  | 1 | 06 |
  | 2 | 5B |
  | 3 | 4F |
  | 4 | 66 |
  | 5 | 6D |
  | 6 | 7D |
  | 7 | 07 |
  | 8 | 7F |
  | 9 | 6F |
  | 10–15 | 79 ("E") |

  The hundreds digit can only be 0 or 1.
- Capture: when load = 1, shadow <= {cout, f} and pending <= 1. This happens in any state.
- Commit happens on the BLANK→SHOW edge with idx == 0 (frame start). If pending == 1 at that edge: disp <= shadow and pending <= 0.
- Simultaneous load and commit in the same cycle:
  - disp takes the old shadow;
  - shadow takes the new value;
  - pending stays 1, so the new value commits at the next frame start.
- Multiple loads within one frame: the last one wins.
- Frame period is 3*(DIV + BLANK_CYC) cycles. cnt is sized as $clog2 of max(DIV, BLANK_CYC).

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- When defined:
  - In the hundreds SHOW slot with disp.cout == 0: an = 111, seg = 00.
  - In the tens SHOW slot with disp.cout == 0 and disp.f[7:4] == 0: an = 111, seg = 00.
  - The ones digit is never blanked.
  - Slot timing is unchanged.
- When undefined: all three digits are always displayed, including leading zeros.

Decomposition:
- Package bcd_disp_pkg holds:
  - segment constants SEG_0..SEG_9, SEG_E, SEG_OFF;
  - state enum {ST_BLANK, ST_SHOW};
  - digit index constants DIG_ONES = 0, DIG_TENS = 1, DIG_HUND = 2.
- Sub-module bcd_to_seg7: combinational 4-bit to 7-segment decoder, with "E" for inputs greater than 9. It is instantiated once on the muxed digit.

Test Plan:
All scenarios use DIV = 4 and BLANK_CYC = 2, giving an 18-cycle frame.
1. Reset:
   - While rst is held: an = 111, seg = 00, pending = 0.
   - After release: 2 blank cycles, then an = 110 and seg = 3F for 4 cycles; the tens and hundreds slots also show 3F.
2. Load cout = 1, f = 8'h47 mid-frame:
   - pending = 1 until the next frame start.
   - Then the ones slot shows 07 (an = 110), tens shows 66 (an = 101), hundreds shows 06 (an = 011).
   - pending returns to 0.
3. Load f = 8'hA3, cout = 0: ones shows 4F, tens shows 79 ("E"), hundreds shows 3F.
4. Two loads in one frame (8'h12, then 8'h98): the next frame displays 98 only. A load on the commit cycle itself leaves pending = 1 and commits one frame later.
5. Assert rst during a SHOW slot: an = 111 and seg = 00 immediately (asynchronous); disp and pending clear; display resumes showing 0.
6. f = 8'h05, cout = 0:
   - With LEADING_ZERO_BLANK_EN: the tens and hundreds slots give an = 111 and seg = 00; ones shows 6D.
   - Without the macro: tens and hundreds show 3F.
